// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider.
// Contents: FSM state encoding, result-select codes, iteration count and
// the all-ones quotient returned for a zero divisor.
package div_iter_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_ITER   = DIV_DATA_W;

    localparam logic DIV_SEL_QUO = 1'b0;
    localparam logic DIV_SEL_REM = 1'b1;

    localparam logic [DIV_DATA_W-1:0] DIV_ZERO_QUO = {DIV_DATA_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration (purely combinational).
// Ports:
//   rem, quo, divisor : current partial remainder, shifting dividend/quotient, |divisor|
//   rem_next, quo_next: values after shift-left-by-one and trial subtraction
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    logic [DATA_W:0]   shifted_s;
    logic [DATA_W+1:0] diff_s;

    // Shift {rem,quo} left, trial-subtract, keep the difference when it did not borrow.
    always_comb begin
        shifted_s = {rem, quo[DATA_W-1]};
        diff_s    = {1'b0, shifted_s} - {2'b00, divisor};
        if (diff_s[DATA_W+1]) begin
            rem_next = shifted_s[DATA_W-1:0];
            quo_next = {quo[DATA_W-2:0], 1'b0};
        end else begin
            // rem < divisor always holds, so the kept difference fits in DATA_W bits
            rem_next = diff_s[DATA_W-1:0];
            quo_next = {quo[DATA_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit signed/unsigned divider for the execute stage.
// Ports:
//   clk, rstn      : clock (rising edge), asynchronous active-low reset
//   div_en_in      : op valid, accepted in IDLE or DONE when not flushing
//   div_rd_in      : destination tag, echoed on div_rd_out
//   div_sel_in     : 0 quotient, 1 remainder
//   div_usign      : 1 operands are signed, 0 unsigned
//   div_sr0/sr1    : dividend / divisor
//   div_flush      : cancel any in-flight op
//   div_busy       : op in PREP/CALC/FIX, upstream must stall
//   div_en_out     : one-cycle result-valid pulse (DONE state)
//   div_rd_out     : tag of the completing op
//   result         : quotient or remainder, held until the next completion
module div_iter
    import div_iter_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit ZERO_FAST = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              div_en_in,
    input  logic [4:0]        div_rd_in,
    input  logic              div_sel_in,
    input  logic              div_usign,
    input  logic [DATA_W-1:0] div_sr0,
    input  logic [DATA_W-1:0] div_sr1,
    input  logic              div_flush,
    output logic              div_busy,
    output logic              div_en_out,
    output logic [4:0]        div_rd_out,
    output logic [DATA_W-1:0] result
);

    localparam logic [5:0] CNT_LAST = 6'(DIV_ITER - 1);

    div_state_e        state_r, state_s;
    logic [5:0]        cnt_r;
    logic [4:0]        rd_r;
    logic              sel_r, sgn_r;
    logic [DATA_W-1:0] sr0_r, sr1_r;
    logic [DATA_W-1:0] quo_r, rem_r, dvs_r;
    logic              q_neg_r, r_neg_r, zero_r;
    logic              busy_r, en_out_r;
    logic [4:0]        rd_out_r;
    logic [DATA_W-1:0] result_r;

    logic              accept_s;
    logic [DATA_W-1:0] step_quo_s, step_rem_s;
    logic [DATA_W-1:0] quo_fix_s, rem_fix_s, res_s;

    function automatic logic [DATA_W-1:0] div_neg(input logic [DATA_W-1:0] v);
        return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [DATA_W-1:0] div_abs(input logic [DATA_W-1:0] v, input logic take);
        return (take && v[DATA_W-1]) ? div_neg(v) : v;
    endfunction

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .rem_next (step_rem_s),
        .quo_next (step_quo_s)
    );

    // New ops enter only when no op is in flight; flush wins over a same-cycle request.
    always_comb begin
        accept_s = div_en_in && !div_flush && (state_r == ST_IDLE || state_r == ST_DONE);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        if (div_flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_s = accept_s ? ST_PREP : ST_IDLE;
                ST_PREP: begin
                    if (ZERO_FAST && (sr1_r == '0)) begin
                        state_s = ST_FIX;
                    end else begin
                        state_s = ST_CALC;
                    end
                end
                ST_CALC: state_s = (cnt_r == CNT_LAST) ? ST_FIX : ST_CALC;
                ST_FIX:  state_s = ST_DONE;
                ST_DONE: state_s = accept_s ? ST_PREP : ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Sign correction and result selection; a zero divisor overrides the iterated values.
    always_comb begin
        if (zero_r) begin
            quo_fix_s = DIV_ZERO_QUO;
            rem_fix_s = sr0_r;
        end else begin
            quo_fix_s = q_neg_r ? div_neg(quo_r) : quo_r;
            rem_fix_s = r_neg_r ? div_neg(rem_r) : rem_r;
        end
        res_s = (sel_r == DIV_SEL_REM) ? rem_fix_s : quo_fix_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, magnitude preparation and iteration datapath.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r   <= 6'd0;
            rd_r    <= 5'd0;
            sel_r   <= 1'b0;
            sgn_r   <= 1'b0;
            sr0_r   <= '0;
            sr1_r   <= '0;
            quo_r   <= '0;
            rem_r   <= '0;
            dvs_r   <= '0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                rd_r  <= div_rd_in;
                sel_r <= div_sel_in;
                sgn_r <= div_usign;
                sr0_r <= div_sr0;
                sr1_r <= div_sr1;
            end
            case (state_r)
                ST_PREP: begin
                    quo_r   <= div_abs(sr0_r, sgn_r);
                    dvs_r   <= div_abs(sr1_r, sgn_r);
                    rem_r   <= '0;
                    cnt_r   <= 6'd0;
                    q_neg_r <= sgn_r & (sr0_r[DATA_W-1] ^ sr1_r[DATA_W-1]);
                    r_neg_r <= sgn_r & sr0_r[DATA_W-1];
                    zero_r  <= (sr1_r == '0);
                end
                ST_CALC: begin
                    quo_r <= step_quo_s;
                    rem_r <= step_rem_s;
                    cnt_r <= cnt_r + 6'd1;
                end
                default: begin
                end
            endcase
            if (div_flush) begin
                cnt_r <= 6'd0;
            end
        end
    end

    // Registered outputs: busy/valid follow the next state, result/tag load on FIX exit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_r   <= 1'b0;
            en_out_r <= 1'b0;
            rd_out_r <= 5'd0;
            result_r <= '0;
        end else begin
            busy_r   <= (state_s == ST_PREP) || (state_s == ST_CALC) || (state_s == ST_FIX);
            en_out_r <= (state_s == ST_DONE);
            if (state_r == ST_FIX && !div_flush) begin
                result_r <= res_s;
                rd_out_r <= rd_r;
            end
        end
    end

    assign div_busy   = busy_r;
    assign div_en_out = en_out_r;
    assign div_rd_out = rd_out_r;
    assign result     = result_r;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: two instances (zero-divisor fast path on
// and off) share one stimulus stream; expected values come from directed
// constants and from a plain-arithmetic reference model.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en_in;
    logic [4:0]  rd_in;
    logic        sel_in;
    logic        usign;
    logic [31:0] sr0, sr1;
    logic        flush;

    logic        busy0, en0, busy1, en1;
    logic [4:0]  rd0, rd1;
    logic [31:0] res0, res1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_iter #(.DATA_W(32), .ZERO_FAST(1'b1)) u_fast (
        .clk(clk), .rstn(rstn), .div_en_in(en_in), .div_rd_in(rd_in),
        .div_sel_in(sel_in), .div_usign(usign), .div_sr0(sr0), .div_sr1(sr1),
        .div_flush(flush), .div_busy(busy0), .div_en_out(en0),
        .div_rd_out(rd0), .result(res0)
    );

    div_iter #(.DATA_W(32), .ZERO_FAST(1'b0)) u_full (
        .clk(clk), .rstn(rstn), .div_en_in(en_in), .div_rd_in(rd_in),
        .div_sel_in(sel_in), .div_usign(usign), .div_sr0(sr0), .div_sr1(sr1),
        .div_flush(flush), .div_busy(busy1), .div_en_out(en1),
        .div_rd_out(rd1), .result(res1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: integer division rules, 64-bit signed arithmetic avoids the INT_MIN/-1 trap.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic sg, input logic sel);
        logic [31:0] q, r;
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return sel ? r : q;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input logic sel, input logic [4:0] rd);
        sr0    = a;
        sr1    = b;
        usign  = sg;
        sel_in = sel;
        rd_in  = rd;
        en_in  = 1'b1;
    endtask

    // Called just after the accepting edge; cycle 1 is the following negedge.
    task automatic collect(input string tag, input logic [31:0] exp, input logic [4:0] exp_rd,
                           input int lat_fast, input int start, input bit keep_en);
        int lat0 = 0;
        int lat1 = 0;
        logic [31:0] r0 = '0, r1 = '0;
        logic [4:0]  t0 = '0, t1 = '0;
        for (int cyc = start; cyc <= 60 && (lat0 == 0 || lat1 == 0); cyc++) begin
            @(negedge clk);
            if (!keep_en) en_in = 1'b0;
            if (en0 && lat0 == 0) begin lat0 = cyc; r0 = res0; t0 = rd0; end
            if (en1 && lat1 == 0) begin lat1 = cyc; r1 = res1; t1 = rd1; end
        end
        chk($sformatf("%s lat_fast", tag), 32'(lat0), 32'(lat_fast));
        chk($sformatf("%s res_fast", tag), r0, exp);
        chk($sformatf("%s rd_fast", tag), 32'(t0), 32'(exp_rd));
        chk($sformatf("%s lat_full", tag), 32'(lat1), 32'd35);
        chk($sformatf("%s res_full", tag), r1, exp);
        chk($sformatf("%s rd_full", tag), 32'(t1), 32'(exp_rd));
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic sg, input logic sel, input logic [4:0] rd,
                      input logic [31:0] exp);
        drive(a, b, sg, sel, rd);
        @(posedge clk);
        collect(tag, exp, rd, (b == 32'd0) ? 3 : 35, 1, 1'b0);
    endtask

    initial begin
        int pulses;
        logic [31:0] a, b;
        logic sg, sel;
        logic [4:0] rd;

        rstn = 1'b0; en_in = 1'b0; flush = 1'b0; rd_in = 5'd0;
        sel_in = 1'b0; usign = 1'b0; sr0 = 32'd0; sr1 = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy0), 32'd0);
        chk("rst en_out", 32'(en0), 32'd0);
        chk("rst rd_out", 32'(rd0), 32'd0);
        chk("rst result", res0, 32'd0);
        chk("rst busy_full", 32'(busy1), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived results
        op("u100/7 quo", 32'd100, 32'd7, 1'b0, 1'b0, 5'd5, 32'd14);
        op("u100/7 rem", 32'd100, 32'd7, 1'b0, 1'b1, 5'd6, 32'd2);
        op("s-7/2 quo", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 5'd1, 32'hFFFF_FFFD);
        op("s-7/2 rem", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 5'd2, 32'hFFFF_FFFF);
        op("s7/-2 quo", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 5'd3, 32'hFFFF_FFFD);
        op("s7/-2 rem", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 5'd4, 32'd1);
        op("s ovf quo", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd7, 32'h8000_0000);
        op("s ovf rem", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd8, 32'd0);
        op("u big quo", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd9, 32'd0);
        op("u big rem", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd10, 32'h8000_0000);
        op("u x/0 quo", 32'h1234, 32'd0, 1'b0, 1'b0, 5'd11, 32'hFFFF_FFFF);
        op("u x/0 rem", 32'h1234, 32'd0, 1'b0, 1'b1, 5'd12, 32'h1234);
        op("s x/0 quo", 32'h1234, 32'd0, 1'b1, 1'b0, 5'd13, 32'hFFFF_FFFF);
        op("s -x/0 rem", 32'hFFFF_EDCC, 32'd0, 1'b1, 1'b1, 5'd14, 32'hFFFF_EDCC);

        // en_in held high with other operands while busy: ignored, then taken in DONE
        drive(32'd1000, 32'd10, 1'b0, 1'b0, 5'd15);
        @(posedge clk);
        @(negedge clk);
        chk("held busy", 32'(busy0), 32'd1);
        drive(32'd50, 32'd8, 1'b0, 1'b1, 5'd16);
        collect("held A", 32'd100, 5'd15, 35, 2, 1'b1);
        @(posedge clk);
        collect("held B", 32'd2, 5'd16, 35, 1, 1'b0);

        // Flush during DONE together with a new request: pulse stays, request dropped
        flush = 1'b1;
        drive(32'd77, 32'd7, 1'b0, 1'b0, 5'd17);
        @(negedge clk);
        flush = 1'b0;
        en_in = 1'b0;
        chk("flush done en_out", 32'(en0), 32'd0);
        chk("flush beats en busy", 32'(busy0), 32'd0);
        chk("flush beats en busy_full", 32'(busy1), 32'd0);

        // Flush mid-CALC: cancelled op never completes, next op runs normally
        drive(32'd1000, 32'd7, 1'b0, 1'b0, 5'd18);
        @(posedge clk);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            en_in = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 32'(busy0), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (en0 || en1) pulses++;
        end
        chk("flush no pulse", 32'(pulses), 32'd0);
        op("after flush 9/3", 32'd9, 32'd3, 1'b0, 1'b0, 5'd19, 32'd3);

        // Asynchronous reset mid-CALC clears outputs without waiting for an edge
        drive(32'd500, 32'd3, 1'b0, 1'b0, 5'd20);
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en_in = 1'b0;
        end
        #2 rstn = 1'b0;
        #1;
        chk("arst busy", 32'(busy0), 32'd0);
        chk("arst en_out", 32'(en0), 32'd0);
        chk("arst rd_out", 32'(rd0), 32'd0);
        chk("arst result", res0, 32'd0);
        chk("arst result_full", res1, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (en0 || en1) pulses++;
        end
        chk("arst no pulse", 32'(pulses), 32'd0);

        // Randomised back-to-back ops against the reference model
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'($urandom_range(0, 20)); b = $urandom; end
                3: b = 32'd0 - 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            sg  = 1'($urandom_range(0, 1));
            sel = 1'($urandom_range(0, 1));
            rd  = 5'($urandom_range(0, 31));
            op($sformatf("rnd%0d %h/%h s%0d", n, a, b, sg), a, b, sg, sel, rd,
               ref_result(a, b, sg, sel));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
